// File: rtl/psum_serializer_pkg.sv
// rtl/psum_serializer_pkg.sv - shared widths and helpers for the psum output serializer
package psum_serializer_pkg;

  localparam int COL    = 8;
  localparam int PSUM_W = 20;
  localparam int SUM_W  = PSUM_W + 4;
  localparam int ROW_W  = PSUM_W * COL + SUM_W;
  localparam int DEPTH  = 4;
  localparam int BEAT_W = $clog2(COL + 1);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  function automatic logic [SUM_W-1:0] sext_psum(input logic [PSUM_W-1:0] p);
    return {{(SUM_W - PSUM_W){p[PSUM_W-1]}}, p};
  endfunction

endpackage

// File: rtl/psum_row_fifo.sv
// rtl/psum_row_fifo.sv - row-wide FIFO holding captured psum rows until drained
module psum_row_fifo
  import psum_serializer_pkg::*;
#(
  parameter int W = ROW_W,
  parameter int N = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(N+1)-1:0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic [W-1:0]  mem_q [N];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Storage is deliberately not reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + PW'(1);
    if (pop_i)  rptr_d = rptr_q + PW'(1);
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // A push while full always coincides with a pop, so the head is read before it is overwritten.
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(N));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/psum_serializer.sv
// rtl/psum_serializer.sv - captures psum rows and streams them out one word per beat
module psum_serializer
  import psum_serializer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PSUM_W*COL-1:0]   out_in,
  input  logic [SUM_W-1:0]        sum_in,
  input  logic                    cap,
  output logic                    full,
  output logic [CNT_W-1:0]        count,
  output logic                    ovf,
  output logic [SUM_W-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last
);

  logic [ROW_W-1:0]  head_row;
  logic              empty;
  logic              xfer, last_beat, pop, push;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              ovf_q, ovf_d;

  assign dout_valid = !empty;
  assign last_beat  = (beat_q == BEAT_W'(COL));
  assign xfer       = dout_valid && dout_ready;
  assign pop        = xfer && last_beat;
  assign push       = cap && (!full || pop);

  psum_row_fifo #(
    .W (ROW_W),
    .N (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({sum_in, out_in}),
    .rdata_o (head_row),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    beat_d = beat_q;
    if (xfer) beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
    ovf_d = ovf_q | (cap && full && !pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;

  // Beat mux decodes only registered state, so dout holds while the consumer stalls.
  always_comb begin
    dout      = '0;
    dout_last = 1'b0;
    if (dout_valid) begin
      if (last_beat) begin
        dout      = head_row[ROW_W-1 -: SUM_W];
        dout_last = 1'b1;
      end else begin
        for (int k = 0; k < COL; k++) begin
          if (beat_q == BEAT_W'(k)) dout = sext_psum(head_row[k*PSUM_W +: PSUM_W]);
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_serializer.sv
// tb/tb_psum_serializer.sv - directed self-checking bench for psum_serializer
module tb_psum_serializer;
  import psum_serializer_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [PSUM_W*COL-1:0] out_in;
  logic [SUM_W-1:0]      sum_in;
  logic                  cap;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic                  ovf;
  logic [SUM_W-1:0]      dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_last;

  psum_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .out_in     (out_in),
    .sum_in     (sum_in),
    .cap        (cap),
    .full       (full),
    .count      (count),
    .ovf        (ovf),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PSUM_W-1:0] psum_tab [10][COL];
  logic [SUM_W-1:0]  sum_tab  [10];
  logic [SUM_W-1:0]  beat_tab [10][COL+1];

  typedef struct {
    bit          cap;
    bit          ready;
    bit          e_valid;
    logic [23:0] e_dout;
    bit          e_last;
    int          e_count;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_row(input int sel);
    for (int k = 0; k < COL; k++) out_in[k*PSUM_W +: PSUM_W] = psum_tab[sel][k];
    sum_in = sum_tab[sel];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks beats [b0, b1) of row sel with dout_ready already high.
  task automatic drain_beats(input int sel, input int b0, input int b1);
    for (int b = b0; b < b1; b++) begin
      chk($sformatf("drain_r%0d_b%0d_dout", sel, b), 32'(dout), 32'(beat_tab[sel][b]));
      chk($sformatf("drain_r%0d_b%0d_last", sel, b), 32'(dout_last), 32'(b == COL));
      chk($sformatf("drain_r%0d_b%0d_valid", sel, b), 32'(dout_valid), 32'd1);
      step();
    end
  endtask

  initial begin
    // Row 0: columns k+1, sum 36.
    for (int k = 0; k < COL; k++) begin
      psum_tab[0][k] = 20'(k + 1);
      beat_tab[0][k] = 24'(k + 1);
    end
    sum_tab[0] = 24'd36;  beat_tab[0][COL] = 24'd36;
    // Row 1: signed extremes in the low columns.
    psum_tab[1][0] = 20'hFFFFE;  beat_tab[1][0] = 24'hFFFFFE;
    psum_tab[1][1] = 20'h7FFFF;  beat_tab[1][1] = 24'h07FFFF;
    psum_tab[1][2] = 20'h80000;  beat_tab[1][2] = 24'hF80000;
    for (int k = 3; k < COL; k++) begin
      psum_tab[1][k] = 20'(k);
      beat_tab[1][k] = 24'(k);
    end
    sum_tab[1] = 24'h123456;  beat_tab[1][COL] = 24'h123456;
    // Rows 2..9: small distinct positives so ordering errors show up.
    for (int n = 2; n < 10; n++) begin
      for (int k = 0; k < COL; k++) begin
        psum_tab[n][k] = 20'(n * 16 + k);
        beat_tab[n][k] = 24'(n * 16 + k);
      end
      sum_tab[n] = 24'(n * 1000);  beat_tab[n][COL] = 24'(n * 1000);
    end

    vecs[0] = '{cap: 1, ready: 1, e_valid: 1, e_dout: 24'd1, e_last: 0, e_count: 1};
    for (int i = 1; i < 8; i++)
      vecs[i] = '{cap: 0, ready: 1, e_valid: 1, e_dout: 24'(i + 1), e_last: 0, e_count: 1};
    vecs[8] = '{cap: 0, ready: 1, e_valid: 1, e_dout: 24'd36, e_last: 1, e_count: 1};
    vecs[9] = '{cap: 0, ready: 1, e_valid: 0, e_dout: 24'd0, e_last: 0, e_count: 0};

    reset = 1'b1; cap = 1'b0; dout_ready = 1'b0; out_in = '0; sum_in = '0;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_last", 32'(dout_last), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    reset = 1'b0;
    step();

    // Single row at full throughput.
    load_row(0);
    for (int i = 0; i < 10; i++) begin
      cap = vecs[i].cap;
      dout_ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].e_dout));
      chk($sformatf("vec%0d_last", i), 32'(dout_last), 32'(vecs[i].e_last));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
    end
    cap = 1'b0;

    // Negative psum sign extension plus backpressure pattern 1,0,0,1.
    begin
      bit pat [4] = '{1, 0, 0, 1};
      int idx = 0;
      int xfers = 0;
      load_row(1);
      cap = 1'b1; dout_ready = 1'b0;
      step();
      cap = 1'b0;
      chk("neg_col0_dout", 32'(dout), 32'h00FFFFFE);
      chk("neg_count", 32'(count), 32'd1);
      for (int cyc = 0; cyc < 60 && idx < COL + 1; cyc++) begin
        chk($sformatf("bp_c%0d_dout", cyc), 32'(dout), 32'(beat_tab[1][idx]));
        chk($sformatf("bp_c%0d_last", cyc), 32'(dout_last), 32'(idx == COL));
        chk($sformatf("bp_c%0d_valid", cyc), 32'(dout_valid), 32'd1);
        dout_ready = pat[cyc % 4];
        step();
        if (pat[cyc % 4]) begin
          idx++;
          xfers++;
        end
      end
      dout_ready = 1'b0;
      chk("bp_transfers", 32'(xfers), 32'(COL + 1));
      chk("bp_empty_valid", 32'(dout_valid), 32'd0);
      chk("bp_empty_count", 32'(count), 32'd0);
    end

    // Fill to depth with the consumer stalled.
    for (int n = 2; n < 6; n++) begin
      load_row(n);
      cap = 1'b1;
      step();
      chk($sformatf("fill%0d_count", n), 32'(count), 32'(n - 1));
      chk($sformatf("fill%0d_full", n), 32'(full), 32'(n == 5));
    end
    cap = 1'b0;
    chk("fill_ovf", 32'(ovf), 32'd0);

    // Capture on the last-beat pop while full is accepted.
    dout_ready = 1'b1;
    drain_beats(2, 0, COL);
    chk("pop_last_dout", 32'(dout), 32'(beat_tab[2][COL]));
    chk("pop_last_flag", 32'(dout_last), 32'd1);
    load_row(6);
    cap = 1'b1;
    step();
    cap = 1'b0;
    dout_ready = 1'b0;
    chk("cap_pop_count", 32'(count), 32'd4);
    chk("cap_pop_full", 32'(full), 32'd1);
    chk("cap_pop_ovf", 32'(ovf), 32'd0);
    chk("cap_pop_next_head", 32'(dout), 32'(beat_tab[3][0]));

    // Capture while full without pop is dropped.
    load_row(7);
    cap = 1'b1;
    step();
    cap = 1'b0;
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_ovf", 32'(ovf), 32'd1);
    chk("drop_head_held", 32'(dout), 32'(beat_tab[3][0]));

    dout_ready = 1'b1;
    for (int n = 3; n < 7; n++) drain_beats(n, 0, COL + 1);
    chk("drain_end_valid", 32'(dout_valid), 32'd0);
    chk("drain_end_count", 32'(count), 32'd0);
    chk("drain_end_ovf_sticky", 32'(ovf), 32'd1);

    // Reset mid-row clears everything immediately.
    load_row(8);
    cap = 1'b1;
    step();
    cap = 1'b0;
    drain_beats(8, 0, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_last", 32'(dout_last), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dout_ready = 1'b0;
    load_row(9);
    cap = 1'b1;
    step();
    cap = 1'b0;
    chk("post_rst_dout", 32'(dout), 32'(beat_tab[9][0]));
    chk("post_rst_last", 32'(dout_last), 32'd0);
    chk("post_rst_count", 32'(count), 32'd1);
    dout_ready = 1'b1;
    drain_beats(9, 0, COL + 1);
    chk("post_rst_empty", 32'(dout_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_serializer.md
# psum_serializer

Output stage directly downstream of the accelerator core. Captures each completed row of `col` partial sums plus its row sum into a small FIFO when the controller strobes `cap`. Drains every row over a narrow valid/ready stream, one word per beat: `col` psum beats, then one sum beat flagged `dout_last`. Decouples the core's wide, bursty result bus from a slow host or off-chip reader.

## Interface
- `col`, 8, psums per row
- `bw_psum`, 20, psum width (2*bw+4 with bw=8)
- `depth`, 4, FIFO rows; power of two, ≥2
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `out_in`  in  bw_psum*col  psum row; column k at bits [bw_psum*(k+1)-1 : bw_psum*k]
- `sum_in`  in  bw_psum+4  row sum
- `cap`  in  1  capture strobe; samples `out_in`/`sum_in` at this edge
- `full`  out  1  FIFO holds `depth` rows
- `count`  out  $clog2(depth+1)  rows stored
- `ovf`  out  1  sticky: a capture was dropped
- `dout`  out  bw_psum+4  stream word
- `dout_valid`  out  1  `dout` valid
- `dout_ready`  in  1  consumer accepts
- `dout_last`  out  1  current beat is the sum beat (final beat of row)

## Operation
- Reset values:
  - `count`=0, `full`=0, `ovf`=0, `dout_valid`=0, `dout_last`=0, `dout`=0.
  - Read/write pointers and beat counter are 0.
  - Storage RAM is not cleared.
- Capture: a row is accepted when `cap` && (!`full` || pop this cycle). Accepted row is written at the write pointer, which then increments mod `depth`.
- Drop: `cap` && `full` && no pop leaves the FIFO unchanged and sets `ovf`=1. `ovf` clears only on reset.
- Beat sequence per head row, beat counter b = 0..col:
  - b < col: `dout` = column b sign-extended to bw_psum+4, `dout_last`=0.
  - b = col: `dout` = `sum_in` as captured, `dout_last`=1.
- Handshake:
  - `dout_valid` = (`count` != 0).
  - A beat transfers on `dout_valid` && `dout_ready`; b then increments.
  - On the last-beat transfer, b returns to 0 and the row pops (read pointer +1, `count` −1).
  - `dout`, `dout_last`, and `dout_valid` hold steady while `dout_valid` && !`dout_ready`.
  - `dout`=0 and `dout_last`=0 whenever `dout_valid`=0.
- Capture and pop in the same cycle: `count` unchanged. A capture while full is accepted if that cycle pops.
- `cap` ignored while `reset` is high.
- Reset mid-row discards all stored rows and any partially sent row. The stream restarts at b=0 on the next capture.

## Timing
- Capture-to-output latency is one cycle. With the FIFO empty, `cap` sampled at edge N gives `dout_valid`=1 with column 0 on `dout` immediately after edge N.
- Throughput: one beat per cycle with `dout_ready` held high, so one row per col+1 cycles. Sustained capture faster than that fills the FIFO.
- `count`, `full`, `ovf`, `dout_*` are all register-driven or decoded only from registers. There is no combinational path from `cap` or `dout_ready` to any output.
- Reset assertion clears outputs asynchronously. Deassertion takes effect on the next edge.

## Structure
- Shared package holds:
  - width constants: `PSUM_W`=bw_psum, `SUM_W`=bw_psum+4, `ROW_W`=bw_psum*col+SUM_W
  - beat-count width $clog2(col+1)
  - function for sign-extending a psum to `SUM_W`
- Sub-module `psum_row_fifo`:
  - `ROW_W`-wide, `depth`-entry FIFO with pointers, `count`, `full`
  - push/pop ports; no combinational read-before-write
- Top level holds the beat counter, beat mux, `ovf`, and handshake.

## Test plan
- Single row, `dout_ready`=1, columns k=0..7 = k+1, sum=36 → beats 1..8 on consecutive cycles, then 36 with `dout_last`=1; `count` 1→0.
- Negative psum: column 0 = 20'hFFFFE (−2) → first beat `dout`=24'hFFFFFE.
- Backpressure: toggle `dout_ready` 1,0,0,1,… → `dout` held during stalls, no beat skipped or duplicated, 9 transfers total.
- Overflow: `dout_ready`=0, 5 captures with depth 4 → `full`=1 after the 4th, 5th dropped, `ovf`=1, `count`=4; drain yields rows 1–4 in order.
- Full plus simultaneous pop: FIFO full, `cap` on the cycle of a last-beat transfer → capture accepted, `count` stays 4, `ovf` stays 0.
- Reset mid-row: assert `reset` after 3 beats → all outputs 0 at once; a new capture streams from column 0.
